// File: rtl/avalon_flash_csr.sv
// avalon_flash_csr
//   Avalon-MM slave register file for the flash controller. It decodes a
//   16-word register map, launches commands to the flash FSM with a start/ack
//   handshake, tracks completion and ack timeout, and raises a maskable
//   write-1-to-clear interrupt.
// Ports:
//   clk_i, rst_i        clock, synchronous active-low reset
//   avl_*               Avalon-MM slave (word offset, byte enables,
//                       one-cycle read latency, write-only waitrequest)
//   avl_irq_o           interrupt, |(IRQ_STAT & IRQ_EN)
//   mem_ry_byn_i        flash ready/busy, status only
//   mem_rdata_i         result data from the flash FSM, captured on done_i
//   mem_*_o             block/other address, transmit data, command code
//   start_o/ack_i       command request handshake
//   done_i              command completion pulse
module avalon_flash_csr #(
  parameter int DATA_W      = 16,
  parameter int BLK_W       = 7,
  parameter int OFS_W       = 16,
  parameter int CMD_W       = 4,
  parameter int NUM_CMD     = 8,
  parameter int ACK_TIMEOUT = 255,
  parameter logic [DATA_W-1:0] ID_VALUE = DATA_W'(16'hF1A5)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [3:0]          avl_addr_i,
  input  logic [DATA_W-1:0]   avl_wdata_i,
  input  logic [DATA_W/8-1:0] avl_byteenable_i,
  input  logic                avl_write_i,
  input  logic                avl_read_i,
  output logic [DATA_W-1:0]   avl_rdata_o,
  output logic                avl_rdatavalid_o,
  output logic                avl_waitrequest_o,
  output logic                avl_irq_o,
  input  logic                mem_ry_byn_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic [BLK_W-1:0]    mem_block_addr_o,
  output logic [OFS_W-1:0]    mem_other_addr_o,
  output logic [DATA_W-1:0]   mem_dq_o,
  output logic [CMD_W-1:0]    mem_code_o,
  output logic                start_o,
  input  logic                ack_i,
  input  logic                done_i
);

  localparam int NLANE = DATA_W / 8;
  localparam int CNT_W = $clog2(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              start_reg;
  logic [CMD_W-1:0]  code_reg;
  logic [DATA_W-1:0] rx_reg;

  logic [BLK_W-1:0]  block_reg;
  logic [OFS_W-1:0]  other_reg;
  logic [DATA_W-1:0] tx_reg;
  logic [CMD_W-1:0]  cmd_reg;
  logic [3:0]        irq_en_reg;
  logic [3:0]        irq_stat_reg;
  logic              irq_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              rvalid_reg;

  // Byte-lane mask expanded from byteenable.
  logic [DATA_W-1:0] be_mask;
  generate
    for (genvar gi = 0; gi < NLANE; gi++) begin : g_lane
      assign be_mask[8*gi +: 8] = {8{avl_byteenable_i[gi]}};
    end
  endgenerate

  logic              busy;
  logic              guarded_addr;
  logic              wr_acc;
  logic              rd_acc;
  logic              unmapped_evt;
  logic [DATA_W-1:0] wdata_masked;
  logic [DATA_W-1:0] block_merged;
  logic [DATA_W-1:0] other_merged;
  logic [DATA_W-1:0] tx_merged;
  logic [DATA_W-1:0] cmd_merged;
  logic [DATA_W-1:0] en_merged;
  logic [CMD_W-1:0]  cmd_code;
  logic              cmd_legal;
  logic              cmd_wr;
  logic              launch;
  logic              tmo_hit;
  logic [3:0]        irq_set;
  logic [3:0]        irq_clr;
  logic [3:0]        irq_stat_next;
  logic [3:0]        irq_en_next;
  logic [DATA_W-1:0] rd_word;

  assign busy         = (state_reg != ST_IDLE);
  // Registers feeding an in-flight command must not change under it.
  assign guarded_addr = (avl_addr_i == 4'd1) || (avl_addr_i == 4'd2) ||
                        (avl_addr_i == 4'd3) || (avl_addr_i == 4'd6);
  assign avl_waitrequest_o = avl_write_i && busy && guarded_addr;
  assign wr_acc       = avl_write_i && !avl_waitrequest_o;
  // A read colliding with a write is dropped in favour of the write.
  assign rd_acc       = avl_read_i && !avl_write_i;
  assign unmapped_evt = ((avl_read_i || avl_write_i) && (avl_addr_i > 4'd8)) ||
                        (avl_read_i && avl_write_i);

  // Each writable register is merged at full bus width, then truncated.
  assign wdata_masked = avl_wdata_i & be_mask;
  assign block_merged = (DATA_W'(block_reg)  & ~be_mask) | wdata_masked;
  assign other_merged = (DATA_W'(other_reg)  & ~be_mask) | wdata_masked;
  assign tx_merged    = (tx_reg              & ~be_mask) | wdata_masked;
  assign cmd_merged   = (DATA_W'(cmd_reg)    & ~be_mask) | wdata_masked;
  assign en_merged    = (DATA_W'(irq_en_reg) & ~be_mask) | wdata_masked;

  assign cmd_code  = cmd_merged[CMD_W-1:0];
  assign cmd_legal = (cmd_code != '0) && (int'(cmd_code) < NUM_CMD);
  assign cmd_wr    = wr_acc && (avl_addr_i == 4'd6);
  assign launch    = cmd_wr && cmd_legal && (state_reg == ST_IDLE);
  assign tmo_hit   = (cnt_reg == CNT_W'(ACK_TIMEOUT - 1));

  // Set events win over a same-cycle clear.
  assign irq_set[0] = done_i && ((state_reg == ST_WAIT) ||
                                 ((state_reg == ST_ISSUE) && ack_i));
  assign irq_set[1] = cmd_wr && !cmd_legal;
  assign irq_set[2] = (state_reg == ST_ISSUE) && !ack_i && tmo_hit;
  assign irq_set[3] = unmapped_evt;
  assign irq_clr       = (wr_acc && (avl_addr_i == 4'd7)) ? wdata_masked[3:0] : 4'd0;
  assign irq_stat_next = (irq_stat_reg & ~irq_clr) | irq_set;
  assign irq_en_next   = (wr_acc && (avl_addr_i == 4'd8)) ? en_merged[3:0] : irq_en_reg;

  always_comb begin
    rd_word = '0;
    case (avl_addr_i)
      4'd0: rd_word = ID_VALUE;
      4'd1: rd_word = DATA_W'(block_reg);
      4'd2: rd_word = DATA_W'(other_reg);
      4'd3: rd_word = tx_reg;
      4'd4: rd_word = rx_reg;
      4'd5: rd_word = DATA_W'({state_reg, busy, mem_ry_byn_i});
      4'd6: rd_word = DATA_W'(cmd_reg);
      4'd7: rd_word = DATA_W'(irq_stat_reg);
      4'd8: rd_word = DATA_W'(irq_en_reg);
      default: rd_word = '0;
    endcase
  end

  // Command launch FSM.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      start_reg <= 1'b0;
      code_reg  <= '0;
      rx_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (launch) begin
            state_reg <= ST_ISSUE;
            start_reg <= 1'b1;
            cnt_reg   <= '0;
            code_reg  <= cmd_code;
          end
        end
        ST_ISSUE: begin
          if (ack_i) begin
            start_reg <= 1'b0;
            if (done_i) begin
              rx_reg    <= mem_rdata_i;
              state_reg <= ST_IDLE;
            end else begin
              state_reg <= ST_WAIT;
            end
          end else if (tmo_hit) begin
            start_reg <= 1'b0;
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_WAIT: begin
          if (done_i) begin
            rx_reg    <= mem_rdata_i;
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          start_reg <= 1'b0;
        end
      endcase
    end
  end

  // Register file, interrupt block and read port.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      block_reg    <= '0;
      other_reg    <= '0;
      tx_reg       <= '0;
      cmd_reg      <= '0;
      irq_en_reg   <= '0;
      irq_stat_reg <= '0;
      irq_reg      <= 1'b0;
      rdata_reg    <= '0;
      rvalid_reg   <= 1'b0;
    end else begin
      if (wr_acc) begin
        case (avl_addr_i)
          4'd1: block_reg <= block_merged[BLK_W-1:0];
          4'd2: other_reg <= other_merged[OFS_W-1:0];
          4'd3: tx_reg    <= tx_merged;
          4'd6: cmd_reg   <= cmd_code;
          default: ;
        endcase
      end
      irq_en_reg   <= irq_en_next;
      irq_stat_reg <= irq_stat_next;
      irq_reg      <= |(irq_stat_next & irq_en_next);
      rvalid_reg   <= rd_acc;
      if (rd_acc) rdata_reg <= rd_word;
    end
  end

  assign avl_rdata_o      = rdata_reg;
  assign avl_rdatavalid_o = rvalid_reg;
  assign avl_irq_o        = irq_reg;
  assign mem_block_addr_o = block_reg;
  assign mem_other_addr_o = other_reg;
  assign mem_dq_o         = tx_reg;
  assign mem_code_o       = code_reg;
  assign start_o          = start_reg;

endmodule

// File: doc/avalon_flash_csr.md
Name: avalon_flash_csr

Overview:
Parametrised Avalon-MM slave register file for the flash controller; successor to the fixed 16-bit slave interface.
- Decodes a 4-bit word-offset register map with per-byte write enables and fixed-latency reads (readdatavalid).
- Runs a command launch FSM: start/ack handshake to the flash FSM, completion tracking, ack timeout.
- Provides a maskable, write-1-to-clear interrupt block.
- Sits between the system Avalon interconnect and the flash control FSM.

Parameters:
DATA_W, 16, Avalon data width; multiple of 8, 16..32.
BLK_W, 7, block address width, ≤ DATA_W.
OFS_W, 16, other/in-block address width, ≤ DATA_W.
CMD_W, 4, command code width.
NUM_CMD, 8, codes 1..NUM_CMD-1 are legal; 0 and ≥ NUM_CMD are illegal.
ACK_TIMEOUT, 255, cycles start_o may stay high without ack_i before the command aborts; ≥ 2.
ID_VALUE, 16'hF1A5, value of the ID register, zero-extended to DATA_W.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
avl_addr_i  in  4  word offset
avl_wdata_i  in  DATA_W  write data
avl_byteenable_i  in  DATA_W/8  byte lanes
avl_write_i  in  1  write strobe
avl_read_i  in  1  read strobe
avl_rdata_o  out  DATA_W  read data
avl_rdatavalid_o  out  1  read data valid
avl_waitrequest_o  out  1  stall
avl_irq_o  out  1  interrupt
mem_ry_byn_i  in  1  flash ready (1) / busy (0)
mem_rdata_i  in  DATA_W  data returned by flash FSM
mem_block_addr_o  out  BLK_W  block address
mem_other_addr_o  out  OFS_W  other address
mem_dq_o  out  DATA_W  transmit data
mem_code_o  out  CMD_W  command code
start_o  out  1  command request
ack_i  in  1  flash FSM accepted the command
done_i  in  1  one-cycle pulse: command complete

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-low. While rst_i=0 at a clk_i edge:
  - all registers and outputs go to 0;
  - FSM goes to IDLE;
  - a reset mid-command drops start_o the next cycle, and a late ack_i/done_i is ignored.
- Register map (offset: access, contents):
  - 0: RO, ID_VALUE.
  - 1: RW, BLOCK [BLK_W-1:0].
  - 2: RW, OTHER [OFS_W-1:0].
  - 3: RW, TX [DATA_W-1:0].
  - 4: RO, RX, last mem_rdata_i captured on done_i.
  - 5: RO, STATUS: bit0 mem_ry_byn_i, bit1 busy (FSM≠IDLE), bits3:2 FSM state.
  - 6: RW, CMD [CMD_W-1:0].
  - 7: W1C, IRQ_STAT: bit0 done, bit1 illegal code, bit2 ack timeout, bit3 unmapped access.
  - 8: RW, IRQ_EN [3:0].
  - 9..15: unmapped.
- Width rules:
  - Narrower registers read zero-extended.
  - Writes update only lanes with byteenable=1.
  - Bits above a register's width are ignored.
- Reads:
  - Never stalled.
  - avl_rdata_o is registered; avl_rdatavalid_o=1 exactly one cycle after the read.
  - Unmapped read returns 0 with rdatavalid and sets IRQ_STAT[3].
- Writes:
  - A write to offsets 1, 2, 3 or 6 while busy=1 sees combinational avl_waitrequest_o=1 until busy=0. No register changes while stalled.
  - All other writes complete the same cycle (waitrequest=0).
  - Read and write asserted together: treat as write; set IRQ_STAT[3].
- FSM IDLE → ISSUE → WAIT → IDLE.
  - IDLE, accepted CMD write with legal code:
    - latch mem_code_o;
    - drive BLOCK/OTHER/TX on the mem_* outputs, which hold continuously;
    - go to ISSUE.
  - IDLE, accepted CMD write with illegal code: CMD register updates, no launch, set IRQ_STAT[1].
  - ISSUE:
    - start_o=1; timeout counter increments each cycle.
    - ack_i=1 → next cycle start_o=0, state WAIT.
    - Counter reaches ACK_TIMEOUT-1 without ack_i → start_o=0, set IRQ_STAT[2], return to IDLE.
  - WAIT:
    - done_i=1 → capture mem_rdata_i into RX, set IRQ_STAT[0], go to IDLE.
    - done_i in ISSUE in the same cycle as ack_i: treat as ack followed immediately by done; go to IDLE and set IRQ_STAT[0].
- IRQ:
  - avl_irq_o = |(IRQ_STAT & IRQ_EN), registered.
  - W1C: writing 1 clears a bit.
  - A set event in the same cycle as its clear: the set wins.
- mem_ry_byn_i=0 does not stall the bus; the flash FSM only sees it through ack_i/done_i.

Test Plan:
- Reset then read offsets 0, 5, 8 → rdata 16'hF1A5, 0, 0; rdatavalid exactly 1 cycle after each read; all outputs 0.
- Write BLOCK=16'h00FF with byteenable 2'b01 → mem_block_addr_o=7'h7F. Write OTHER=16'hABCD with byteenable 2'b10 → mem_other_addr_o=16'hAB00.
- Write IRQ_EN=4'h1, then CMD=4'h2 → start_o=1 the next cycle. Assert ack_i after 3 cycles → start_o=0 the following cycle. Pulse done_i with mem_rdata_i=16'h1234 → RX reads 16'h1234, IRQ_STAT=4'h1, avl_irq_o=1.
- While in WAIT, write TX=16'h5555 → waitrequest held high until the cycle after done_i, then TX updates. A read of STATUS during WAIT is not stalled and returns busy=1.
- Write CMD=4'h9 → no start_o; IRQ_STAT[1]=1. Write IRQ_STAT=4'h2 → the bit clears. Illegal-code set in the same cycle as the clear → the bit stays 1.
- CMD=4'h1 with ack_i never asserted, ACK_TIMEOUT=8 → start_o high for exactly 8 cycles, IRQ_STAT[2]=1, FSM back in IDLE. Repeat with rst_i=0 mid-ISSUE → start_o=0 next cycle, all registers 0.
